// File: rtl/bin_a_bcd.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// The last result stays on bcd while the next conversion runs; out-of-range inputs saturate to 9s.
module bin_a_bcd #(
  parameter int unsigned ANCHO_BIN = 27,
  parameter int unsigned DIGITOS   = 8
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [ANCHO_BIN-1:0]   valor,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   desborde,
  output logic [4*DIGITOS-1:0]   bcd
);

  localparam int unsigned AnchoBcd = 4 * DIGITOS;
  localparam int unsigned AnchoCnt = $clog2(ANCHO_BIN + 1);
  localparam logic [AnchoCnt-1:0] CntIni = AnchoCnt'(ANCHO_BIN);

  function automatic logic [63:0] max_decimal(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MaxDec = max_decimal(DIGITOS);

  typedef enum logic [0:0] {StReposo, StDesplaza} estado_e;

  estado_e               r_estado;
  logic [AnchoBcd-1:0]   r_a;
  logic [ANCHO_BIN-1:0]  r_b;
  logic [AnchoCnt-1:0]   r_cnt;
  logic                  r_ovf;

  logic [AnchoBcd-1:0]   w_a_adj;
  logic [AnchoBcd-1:0]   w_a_sig;
  logic [ANCHO_BIN-1:0]  w_b_sig;
  logic [63:0]           w_valor_ext;

  assign w_valor_ext = 64'(valor);

  // Correct every digit >= 5 before the shift so it carries properly into the next digit.
  always_comb begin
    w_a_adj = r_a;
    for (int unsigned i = 0; i < DIGITOS; i++) begin
      if (r_a[4*i +: 4] >= 4'd5) begin
        w_a_adj[4*i +: 4] = r_a[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_a_sig = {w_a_adj[AnchoBcd-2:0], r_b[ANCHO_BIN-1]};
  assign w_b_sig = {r_b[ANCHO_BIN-2:0], 1'b0};

  always_ff @(posedge reloj) begin
    if (reset) begin
      r_estado <= StReposo;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      bcd      <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
      desborde <= 1'b0;
    end else begin
      listo <= 1'b0;
      unique case (r_estado)
        StReposo: begin
          if (inicio) begin
            r_b      <= valor;
            r_a      <= '0;
            r_cnt    <= CntIni;
            r_ovf    <= (w_valor_ext > MaxDec);
            ocupado  <= 1'b1;
            r_estado <= StDesplaza;
          end
        end
        StDesplaza: begin
          r_a   <= w_a_sig;
          r_b   <= w_b_sig;
          r_cnt <= r_cnt - AnchoCnt'(1);
          if (r_cnt == AnchoCnt'(1)) begin
            bcd      <= r_ovf ? {DIGITOS{4'h9}} : w_a_sig;
            desborde <= r_ovf;
            listo    <= 1'b1;
            ocupado  <= 1'b0;
            r_estado <= StReposo;
          end
        end
        default: r_estado <= StReposo;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_a_bcd.sv
// Scoreboard bench for bin_a_bcd: stimulus pushes expected results, a monitor checks each listo.
module tb_bin_a_bcd;

  logic        reloj;
  logic        reset;
  logic        inicio;
  logic [26:0] valor;
  logic        ocupado;
  logic        listo;
  logic        desborde;
  logic [31:0] bcd;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bin_a_bcd #(.ANCHO_BIN(27), .DIGITOS(8)) dut (
    .reloj    (reloj),
    .reset    (reset),
    .inicio   (inicio),
    .valor    (valor),
    .ocupado  (ocupado),
    .listo    (listo),
    .desborde (desborde),
    .bcd      (bcd)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Independent decimal model: digit-by-digit division, saturating above 8 digits.
  function automatic logic [31:0] model_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    if (v > 99999999) return 32'h99999999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(negedge reloj) begin
    if (listo) begin
      if (sb.size() == 0) begin
        check("listo_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", 64'(bcd), 64'(e.bcd));
        check("desborde", 64'(desborde), 64'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // Count negedges until listo (bounded); track ocupado and whether bcd stayed at hold.
  task automatic wait_listo(input logic [31:0] hold, output int n, output int ocup,
                            output bit held);
    n = 0;
    ocup = 0;
    held = 1'b1;
    while (n < 40) begin
      @(negedge reloj);
      n++;
      if (listo) break;
      if (ocupado) ocup++;
      if (bcd !== hold) held = 1'b0;
    end
  endtask

  task automatic run_one(input logic [26:0] v, input logic [31:0] eb, input logic eo,
                         input logic [31:0] hold);
    int n;
    int ocup;
    bit held;
    sb.push_back('{bcd: eb, ovf: eo});
    inicio = 1'b1;
    valor  = v;
    tick();
    inicio = 1'b0;
    valor  = 27'($urandom);
    wait_listo(hold, n, ocup, held);
    check("latency", 64'(n), 64'd28);
    check("ocupado_cycles", 64'(ocup), 64'd27);
    check("bcd_hold", 64'(held), 64'd1);
    check("ocupado_at_listo", 64'(ocupado), 64'd0);
    tick();
    check("listo_one_cycle", 64'(listo), 64'd0);
  endtask

  initial begin
    int n;
    int ocup;
    bit held;
    logic [31:0] prev;
    logic [26:0] vals[$];
    logic [31:0] ebs[$];
    logic        eos[$];

    reset  = 1'b1;
    inicio = 1'b0;
    valor  = '0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge reloj);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_listo", 64'(listo), 64'd0);
    check("rst_ocupado", 64'(ocupado), 64'd0);
    check("rst_desborde", 64'(desborde), 64'd0);
    tick();

    // T1, T2
    run_one(27'd0, 32'h00000000, 1'b0, 32'h0);
    run_one(27'd12345678, 32'h12345678, 1'b0, 32'h0);

    // T3: largest in-range value, then saturation
    run_one(27'd99999999, 32'h99999999, 1'b0, 32'h12345678);
    run_one(27'd100000000, 32'h99999999, 1'b1, 32'h99999999);
    run_one(27'h7FFFFFF, 32'h99999999, 1'b1, 32'h99999999);

    // T4: inicio while busy must be ignored
    sb.push_back('{bcd: 32'h00000042, ovf: 1'b0});
    inicio = 1'b1;
    valor  = 27'd42;
    tick();
    inicio = 1'b0;
    repeat (9) tick();
    inicio = 1'b1;
    valor  = 27'd7;
    tick();
    inicio = 1'b0;
    wait_listo(32'h99999999, n, ocup, held);
    check("t4_latency", 64'(n), 64'd18);
    check("t4_hold", 64'(held), 64'd1);
    repeat (35) tick();

    // T5: reset mid-conversion aborts with no listo
    sb.push_back('{bcd: 32'h00000555, ovf: 1'b0});
    inicio = 1'b1;
    valor  = 27'd555;
    tick();
    inicio = 1'b0;
    repeat (12) tick();
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    @(negedge reloj);
    check("t5_bcd", 64'(bcd), 64'd0);
    check("t5_ocupado", 64'(ocupado), 64'd0);
    check("t5_desborde", 64'(desborde), 64'd0);
    repeat (35) tick();
    run_one(27'd555, 32'h00000555, 1'b0, 32'h0);

    // T6: inicio held high, directed vectors then random sweep
    vals = '{27'd1, 27'd9, 27'd10, 27'd99, 27'd100, 27'd65535, 27'h7FFFFFF, 27'd50000005};
    ebs  = '{32'h1, 32'h9, 32'h10, 32'h99, 32'h100, 32'h65535, 32'h99999999, 32'h50000005};
    eos  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 1000; i++) begin
      int unsigned r;
      if (i % 8 == 0) r = $urandom_range(134217727, 0);
      else r = $urandom_range(99999999, 0);
      vals.push_back(27'(r));
      ebs.push_back(model_bcd(r));
      eos.push_back(r > 99999999);
    end
    prev   = 32'h00000555;
    inicio = 1'b1;
    for (int i = 0; i < vals.size(); i++) begin
      valor = vals[i];
      sb.push_back('{bcd: ebs[i], ovf: eos[i]});
      tick();
      valor = 27'($urandom);
      if (i == vals.size() - 1) inicio = 1'b0;
      wait_listo(prev, n, ocup, held);
      check("t6_period", 64'(n), 64'd28);
      check("t6_hold", 64'(held), 64'd1);
      prev = ebs[i];
    end
    inicio = 1'b0;
    repeat (40) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("idle_ocupado", 64'(ocupado), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
